// File: rtl/fifo_credit_pkg.sv
// Shared types and constants for the credit-based transmit FIFO front end.
package fifo_credit_pkg;

    // Top-level control state: waiting for the initial credit load, or running.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Entries in the input skid buffer.
    localparam int SKID_DEPTH = 2;

    // Width needed to hold every credit count from 0 up to max_credits inclusive.
    function automatic int credit_width(input int max_credits);
        return $clog2(max_credits) + 1;
    endfunction

endpackage

// File: rtl/fifo_credit_skid.sv
// Two-entry FIFO-ordered skid buffer; entry0 is always the head.
module fifo_credit_skid
    import fifo_credit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] entry0_q;
    logic [DATA_WIDTH-1:0] entry1_q;
    logic [1:0]            cnt_q;
    logic                  push_ok;
    logic                  pop_ok;

    // A push into a full buffer is only legal when the head leaves the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Shift-style storage: pops move entry1 forward, pushes land at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            cnt_q    <= 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) entry0_q <= push_data;
                    else               entry1_q <= push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    entry0_q <= entry1_q;
                    cnt_q    <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'(SKID_DEPTH)) begin
                        entry0_q <= entry1_q;
                        entry1_q <= push_data;
                    end else begin
                        entry0_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = entry0_q;
    assign full  = (cnt_q == 2'(SKID_DEPTH));
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/fifo_credit_tx.sv
// Credit-based transmitter: buffers source beats and launches them into a
// downstream FIFO only while credits are held.
module fifo_credit_tx
    import fifo_credit_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    parameter int  MAX_CREDITS = 8,
    localparam int CNT_W       = credit_width(MAX_CREDITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  crd_ret,
    input  logic                  crd_init_valid,
    input  logic [CNT_W-1:0]      crd_init_val,
    output logic [CNT_W-1:0]      credits,
    output logic                  crd_err
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CREDITS);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      credits_q, credits_d;
    logic                  err_q, err_d;
    logic                  in_ready_q, in_ready_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

    logic                  accept;
    logic                  launch;
    logic                  full_next;
    logic [DATA_WIDTH-1:0] skid_head;
    logic                  skid_full;
    logic                  skid_empty;

    assign accept = in_valid && in_ready_q;
    assign launch = (state_q == RUN) && !skid_empty && (credits_q != '0);

    // Fullness after this edge, so in_ready can be registered without a stall bubble.
    assign full_next = skid_full ? (!launch || accept) : (!skid_empty && accept && !launch);

    fifo_credit_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (in_data),
        .pop       (launch),
        .head      (skid_head),
        .full      (skid_full),
        .empty     (skid_empty)
    );

    // Next state, credit accounting, sticky protocol errors and launch outputs.
    always_comb begin
        state_d   = state_q;
        credits_d = credits_q;
        err_d     = err_q;
        unique case (state_q)
            INIT: begin
                if (crd_init_valid) begin
                    state_d = RUN;
                    if (crd_init_val > MaxCnt) begin
                        credits_d = MaxCnt;
                        err_d     = 1'b1;
                    end else begin
                        credits_d = crd_init_val;
                    end
                end
                // Returns before the initial load have nothing to refer to.
                if (crd_ret) err_d = 1'b1;
            end
            RUN: begin
                if (crd_init_valid) err_d = 1'b1;
                if (crd_ret && (credits_q == MaxCnt) && !launch) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q - CNT_W'(launch) + CNT_W'(crd_ret);
                end
            end
            default: ;
        endcase
        in_ready_d = (state_d == RUN) && !full_next;
        tx_valid_d = launch;
        tx_data_d  = launch ? skid_head : tx_data_q;
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            credits_q  <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign in_ready = in_ready_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign credits  = credits_q;
    assign crd_err  = err_q;

endmodule
